// File: rtl/lpc_cycle_decoder_pkg.sv
// Shared LPC decode constants: start codes, cycle/dir codes, sync codes,
// record cycle types and FSM state encodings (also used by the serializer).
package lpc_cycle_decoder_pkg;

  localparam logic [3:0] START_LPC = 4'b0000;
  localparam logic [3:0] START_TPM = 4'b0101;

  // CTDIR[3:1] cycle type / direction
  localparam logic [2:0] CT_IO_RD  = 3'b000;
  localparam logic [2:0] CT_IO_WR  = 3'b001;
  localparam logic [2:0] CT_MEM_RD = 3'b010;
  localparam logic [2:0] CT_MEM_WR = 3'b011;

  localparam logic [3:0] SYNC_READY      = 4'b0000;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
  localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
  localparam logic [3:0] SYNC_ERROR      = 4'b1010;

  localparam logic [1:0] CYC_IO  = 2'd0;
  localparam logic [1:0] CYC_MEM = 2'd1;
  localparam logic [1:0] CYC_TPM = 2'd2;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_START = 4'd1;
  localparam logic [3:0] ST_CTDIR = 4'd2;
  localparam logic [3:0] ST_ADDR  = 4'd3;
  localparam logic [3:0] ST_WDATA = 4'd4;
  localparam logic [3:0] ST_TAR_A = 4'd5;
  localparam logic [3:0] ST_SYNC  = 4'd6;
  localparam logic [3:0] ST_RDATA = 4'd7;
  localparam logic [3:0] ST_TAR_B = 4'd8;

  // Index of the final address nibble: 8 nibbles for MEM, 4 for IO/TPM.
  function automatic logic [2:0] last_addr_nibble(input logic [1:0] cyc);
    return (cyc == CYC_MEM) ? 3'd7 : 3'd3;
  endfunction

endpackage

// File: rtl/lpc_cycle_decoder.sv
// LPC bus cycle decoder: turns registered AD/LFRAME# nibbles into one record
// per completed IO/MEM/TPM cycle; never stalls, drops records when not ready.
module lpc_cycle_decoder
  import lpc_cycle_decoder_pkg::*;
#(
  parameter int unsigned MAX_SYNC_WAIT = 16
) (
  input  logic        lpc_clock,
  input  logic        reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [1:0]  out_cyc,
  output logic        out_write,
  output logic [31:0] out_addr,
  output logic [7:0]  out_data,
  output logic        sync_error,
  output logic        overflow
);

  localparam int unsigned WAIT_W = $clog2(MAX_SYNC_WAIT + 1);

  logic [3:0]        ad_q;
  logic              frame_q, ready_q;
  logic [3:0]        state_q, state_d;
  logic [2:0]        nib_q, nib_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [3:0]        start_q, start_d;
  logic [1:0]        cyc_q, cyc_d;
  logic              write_q, write_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              emit;

  logic              out_valid_q, out_valid_d;
  logic [1:0]        out_cyc_q, out_cyc_d;
  logic              out_write_q, out_write_d;
  logic [31:0]       out_addr_q, out_addr_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              sync_error_q, sync_error_d;
  logic              overflow_q, overflow_d;

  always_comb begin
    state_d      = state_q;
    nib_d        = nib_q;
    wait_d       = wait_q;
    start_d      = start_q;
    cyc_d        = cyc_q;
    write_d      = write_q;
    addr_d       = addr_q;
    data_d       = data_q;
    emit         = 1'b0;
    out_valid_d  = 1'b0;
    sync_error_d = 1'b0;
    overflow_d   = 1'b0;
    out_cyc_d    = out_cyc_q;
    out_write_d  = out_write_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;

    // LFRAME# low overrides everything: the last nibble seen with it low is the start code.
    if (!frame_q) begin
      state_d = ST_START;
      start_d = ad_q;
    end else begin
      case (state_q)
        ST_START: begin
          state_d = ST_IDLE;
          nib_d   = '0;
          wait_d  = '0;
          addr_d  = '0;
          write_d = ad_q[1];
          if (start_q == START_LPC || start_q == START_TPM) begin
            case (ad_q[3:1])
              CT_IO_RD, CT_IO_WR: begin
                state_d = ST_ADDR;
                cyc_d   = (start_q == START_TPM) ? CYC_TPM : CYC_IO;
              end
              CT_MEM_RD, CT_MEM_WR: begin
                if (start_q == START_LPC) begin
                  state_d = ST_ADDR;
                  cyc_d   = CYC_MEM;
                end
              end
              default: state_d = ST_IDLE;
            endcase
          end
        end
        ST_ADDR: begin
          addr_d = {addr_q[27:0], ad_q};
          nib_d  = nib_q + 3'd1;
          if (nib_q == last_addr_nibble(cyc_q)) begin
            nib_d   = '0;
            state_d = write_q ? ST_WDATA : ST_TAR_A;
          end
        end
        ST_WDATA: begin
          data_d = {ad_q, data_q[7:4]};
          nib_d  = nib_q + 3'd1;
          if (nib_q[0]) begin
            nib_d   = '0;
            state_d = ST_TAR_A;
          end
        end
        ST_TAR_A: begin
          nib_d = nib_q + 3'd1;
          if (nib_q[0]) begin
            nib_d   = '0;
            wait_d  = '0;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          case (ad_q)
            SYNC_READY: begin
              if (write_q) begin
                emit    = 1'b1;
                state_d = ST_IDLE;
              end else begin
                state_d = ST_RDATA;
              end
            end
            SYNC_SHORT_WAIT, SYNC_LONG_WAIT: begin
              wait_d = wait_q + 1'b1;
              if (wait_d == WAIT_W'(MAX_SYNC_WAIT)) begin
                sync_error_d = 1'b1;
                state_d      = ST_IDLE;
              end
            end
            SYNC_ERROR: begin
              sync_error_d = 1'b1;
              state_d      = ST_IDLE;
            end
            default: begin
              sync_error_d = 1'b1;
              state_d      = ST_IDLE;
            end
          endcase
        end
        ST_RDATA: begin
          data_d = {ad_q, data_q[7:4]};
          nib_d  = nib_q + 3'd1;
          if (nib_q[0]) begin
            emit    = 1'b1;
            nib_d   = '0;
            state_d = ST_TAR_B;
          end
        end
        ST_TAR_B: begin
          nib_d = nib_q + 3'd1;
          if (nib_q[0]) begin
            nib_d   = '0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Record fields update even when dropped, so out_* always reflect the latest cycle.
    if (emit) begin
      out_cyc_d   = cyc_q;
      out_write_d = write_q;
      out_addr_d  = addr_q;
      out_data_d  = data_d;
      out_valid_d = ready_q;
      overflow_d  = !ready_q;
    end
  end

  always_ff @(posedge lpc_clock) begin
    if (reset) begin
      ad_q         <= '1;
      frame_q      <= 1'b1;
      ready_q      <= 1'b0;
      state_q      <= ST_IDLE;
      nib_q        <= '0;
      wait_q       <= '0;
      start_q      <= '0;
      cyc_q        <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      out_valid_q  <= 1'b0;
      out_cyc_q    <= '0;
      out_write_q  <= 1'b0;
      out_addr_q   <= '0;
      out_data_q   <= '0;
      sync_error_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      ad_q         <= lpc_ad;
      frame_q      <= lpc_frame;
      ready_q      <= out_ready;
      state_q      <= state_d;
      nib_q        <= nib_d;
      wait_q       <= wait_d;
      start_q      <= start_d;
      cyc_q        <= cyc_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      out_cyc_q    <= out_cyc_d;
      out_write_q  <= out_write_d;
      out_addr_q   <= out_addr_d;
      out_data_q   <= out_data_d;
      sync_error_q <= sync_error_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_cyc    = out_cyc_q;
  assign out_write  = out_write_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign sync_error = sync_error_q;
  assign overflow   = overflow_q;

endmodule
